// File: rtl/regfile_dump_pkg.sv
// rtl/regfile_dump_pkg.sv - shared types for the register file dump engine
package regfile_dump_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SEND  = 2'd2,
    ST_DONE  = 2'd3
  } dump_state_t;

endpackage

// File: rtl/regfile_dump.sv
// rtl/regfile_dump.sv - walks a register file read port and streams every word out with a valid/ready handshake
module regfile_dump
  import regfile_dump_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int REG_COUNT = 32,
  parameter int REG_BITS  = $clog2(REG_COUNT)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  output logic [REG_BITS-1:0] rd_addr,
  input  logic [WIDTH-1:0]    rd_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    out_data,
  output logic [REG_BITS-1:0] out_index,
  output logic                out_last,
  output logic                busy,
  output logic                done
);

  localparam logic [REG_BITS-1:0] LAST_IDX = REG_BITS'(REG_COUNT - 1);

  dump_state_t         state;
  logic [REG_BITS-1:0] idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      idx       <= '0;
      rd_addr   <= '0;
      out_data  <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            idx     <= '0;
            rd_addr <= '0;
            busy    <= 1'b1;
            state   <= ST_FETCH;
          end
        end

        ST_FETCH: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            out_data  <= rd_data;
            out_index <= idx;
            out_last  <= (idx == LAST_IDX);
            out_valid <= 1'b1;
            state     <= ST_SEND;
          end
        end

        ST_SEND: begin
          // abort wins over a same-cycle handshake; that word is still considered delivered
          if (abort) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            if (out_last) begin
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              idx     <= idx + REG_BITS'(1);
              rd_addr <= idx + REG_BITS'(1);
              state   <= ST_FETCH;
            end
          end
        end

        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
